cla_mp_sequencer: RTL and testbench

CLA_MP_SEQUENCER -- requirements
Module: cla_mp_sequencer

---
 rtl/cla_mp_sequencer_if.sv | 47 ++++
 rtl/cla_mp_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_cla_mp_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cla_mp_sequencer_if.sv
// rtl/cla_mp_sequencer_if.sv - operand/result handshake bundle for cla_mp_sequencer
//
// Purpose: groups the operand-side and result-side handshakes of the
//          multi-precision adder sequencer.
// Signals:
//   in_valid / in_ready     operand set offered / accepted (IDLE only)
//   op_a, op_b              16*WORDS-bit addends, word 0 = bits [15:0]
//   carry_in                carry into word 0
//   out_valid / out_ready   result presented / consumed
//   sum, carry_out          16*WORDS-bit result and carry out of top word
//   busy                    high while an operation is in RUN or DONE
//   overflow                signed overflow of top word (only with
//                           CLA_MP_SEQUENCER_OVF_EN defined)
// Modports: master = producer/consumer side, slave = sequencer side.
interface cla_mp_sequencer_if #(
    parameter int WORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   op_a;
    logic [16*WORDS-1:0]   op_b;
    logic                  carry_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   sum;
    logic                  carry_out;
    logic                  busy;
`ifdef CLA_MP_SEQUENCER_OVF_EN
    logic                  overflow;
`endif

    modport master (
        output in_valid, op_a, op_b, carry_in, out_ready,
`ifdef CLA_MP_SEQUENCER_OVF_EN
        input  overflow,
`endif
        input  in_ready, out_valid, sum, carry_out, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, carry_in, out_ready,
`ifdef CLA_MP_SEQUENCER_OVF_EN
        output overflow,
`endif
        output in_ready, out_valid, sum, carry_out, busy
    );
endinterface

// File: rtl/cla_mp_sequencer.sv
// rtl/cla_mp_sequencer.sv - word-serial multi-precision adder around one 16-bit CLA
//
// Purpose: adds two 16*WORDS-bit operands one 16-bit word per cycle using a
//          single carry-lookahead adder, with a valid/ready handshake on both
//          the operand and the result side.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     cla_mp_sequencer_if.slave (in_valid/in_ready/op_a/op_b/carry_in,
//           out_valid/out_ready/sum/carry_out/busy[/overflow])
// Configuration:
//   CLA_MP_SEQUENCER_OVF_EN  when defined, bus.overflow reports two's-complement
//                            overflow of the top word alongside the result.

module cla_adder16 (
    output logic [15:0] sum,
    output logic        carry_out,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;
    logic [16:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Group generate/propagate per nibble, then group carries by lookahead;
    // bit carries inside a nibble start from the group carry-in.
    always_comb begin
        w_gg = '0;
        w_gp = '0;
        w_gc = '0;
        w_c  = '0;
        for (int k = 0; k < 4; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp[k] = &w_p[4*k +: 4];
        end
        w_gc[0] = carry_in;
        for (int k = 0; k < 4; k++) begin
            w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            w_c[4*k] = w_gc[k];
            for (int j = 0; j < 3; j++) begin
                w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
            end
        end
        w_c[16] = w_gc[4];
    end

    assign sum       = w_p ^ w_c[15:0];
    assign carry_out = w_c[16];
endmodule

module cla_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cla_mp_sequencer_if.slave       bus
);
    localparam int                 W     = 16 * WORDS;
    localparam int                 IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0]   LAST  = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_carry;      // running carry between words
    logic             r_carry_out;  // published carry, only touched on last word
    logic [IDX_W-1:0] r_idx;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;
    logic             w_capture;
    logic             w_step;
    logic [15:0]      w_a_word;
    logic [15:0]      w_b_word;
    logic [15:0]      w_sum_word;
    logic             w_cout;

    cla_adder16 u_add (
        .sum       (w_sum_word),
        .carry_out (w_cout),
        .a         (w_a_word),
        .b         (w_b_word),
        .carry_in  (r_carry)
    );

    // Select word r_idx of the captured operands.
    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_word = r_a[16*k +: 16];
                w_b_word = r_b[16*k +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_idx == LAST) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_idx       <= '0;
        end else if (w_capture) begin
            r_a     <= bus.op_a;
            r_b     <= bus.op_b;
            r_carry <= bus.carry_in;
            r_idx   <= '0;
        end else if (w_step) begin
            r_carry <= w_cout;
            for (int k = 0; k < WORDS; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_sum[16*k +: 16] <= w_sum_word;
                end
            end
            if (r_idx == LAST) begin
                r_idx       <= '0;
                r_carry_out <= w_cout;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef CLA_MP_SEQUENCER_OVF_EN
    // Carry into the sign bit is recovered from a^b^sum at bit 15 of the top word.
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_step && (r_idx == LAST)) begin
            r_ovf <= (w_a_word[15] ^ w_b_word[15] ^ w_sum_word[15]) ^ w_cout;
        end
    end

    assign bus.overflow = r_ovf;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;
endmodule

// File: tb/tb_cla_mp_sequencer.sv
// tb/tb_cla_mp_sequencer.sv - directed self-checking bench for cla_mp_sequencer (WORDS=4)
module tb_cla_mp_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    cla_mp_sequencer_if #(.WORDS(4)) bus ();

    cla_mp_sequencer #(.WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer an operand set; returns one step after the capture edge.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic cin);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.carry_in = cin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("capture_busy", {63'd0, bus.busy}, 64'd1);
        chk("capture_in_ready", {63'd0, bus.in_ready}, 64'd0);
    endtask

    // Called just after the capture edge: out_valid must rise on the 4th edge.
    task automatic wait_done(input string tag, input logic [63:0] exp_sum,
                             input logic exp_cout, input logic exp_ovf, input bit scramble);
        for (int k = 1; k <= 4; k++) begin
            if (scramble) begin
                bus.op_a = {$urandom, $urandom};
                bus.op_b = {$urandom, $urandom};
                bus.carry_in = 1'($urandom);
            end
            tick();
            chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, (k == 4) ? 64'd1 : 64'd0);
        end
        chk({tag, "_sum"}, bus.sum, exp_sum);
        chk({tag, "_carry_out"}, {63'd0, bus.carry_out}, {63'd0, exp_cout});
`ifdef CLA_MP_SEQUENCER_OVF_EN
        chk({tag, "_overflow"}, {63'd0, bus.overflow}, {63'd0, exp_ovf});
`endif
    endtask

    task automatic finish_op(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_post_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({tag, "_post_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_sum", bus.sum, 64'd0);
        chk("rst_carry_out", {63'd0, bus.carry_out}, 64'd0);
`ifdef CLA_MP_SEQUENCER_OVF_EN
        chk("rst_overflow", {63'd0, bus.overflow}, 64'd0);
`endif
        rst_n = 1'b1;

        // Carry out of word 0 into word 1
        start_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_FFFF, 1'b0);
        wait_done("t1", 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        finish_op("t1");

        // All ones + all ones + 1
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_done("t2", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        finish_op("t2");
        tick();
        tick();
        chk("t2_idle_hold_sum", bus.sum, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_idle_hold_cout", {63'd0, bus.carry_out}, 64'd1);

        // Signed overflow into the sign bit
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        wait_done("t3", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        finish_op("t3");

        // Hold DONE for 5 cycles with in_valid asserted for the next set
        start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1);
        wait_done("t4", 64'h2345_6789_ABCD_F002, 1'b0, 1'b0, 1'b0);
        bus.op_a     = 64'h8000_0000_0000_0000;
        bus.op_b     = 64'h8000_0000_0000_0000;
        bus.carry_in = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("t4_hold_sum", bus.sum, 64'h2345_6789_ABCD_F002);
            chk("t4_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t4_release_busy", {63'd0, bus.busy}, 64'd0);
        chk("t4_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("t4_release_sum", bus.sum, 64'h2345_6789_ABCD_F002);
        tick();
        bus.in_valid = 1'b0;
        chk("t5_capture_busy", {63'd0, bus.busy}, 64'd1);
        wait_done("t5", 64'h0000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        finish_op("t5");

        // Reset pulse during RUN cycle 2
        start_op(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_rst_sum", bus.sum, 64'd0);
        chk("t6_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("t6_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("t6_rst_cout", {63'd0, bus.carry_out}, 64'd0);
        rst_n = 1'b1;
        start_op(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0);
        wait_done("t6", 64'h0000_0000_0000_000C, 1'b0, 1'b0, 1'b0);
        finish_op("t6");

        // Inputs scrambled during RUN, out_ready held high throughout
        bus.out_ready = 1'b1;
        tick();
        chk("t7_idle_out_ready_ignored", {63'd0, bus.in_ready}, 64'd1);
        start_op(64'h0000_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1);
        wait_done("t7", 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        tick();
        bus.out_ready = 1'b0;
        chk("t7_post_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t7_post_sum", bus.sum, 64'h0001_0000_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
